// File: rtl/accum_counter_pkg.sv
// accum_counter_pkg
//   Shared definitions for accum_counter and its pattern register:
//   - mode_e      : operation encodings driven on the mode port
//   - alt_pattern : builds the default 1010... seed, MSB first, w bits wide
package accum_counter_pkg;

    typedef enum logic [1:0] {
        MODE_ACC  = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Bit w-1 is 1, then alternating down to bit 0 (8 bits -> 8'hAA).
    function automatic logic [31:0] alt_pattern(input int unsigned w);
        logic [31:0] p;
        p = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w && ((w - 1 - i) % 2) == 0) p[i] = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/accum_counter_pattern_toggler.sv
// pattern_toggler
//   Holds the pattern register r. It is reloaded with SEED on clr or load and
//   bitwise inverted on inv. Nothing changes unless e is high (clr excepted).
//   Ports:
//     clk  in   clock, rising edge
//     clr  in   synchronous active-high reset, r <= SEED
//     e    in   update enable
//     inv  in   invert r (ACC)
//     load in   reload r with SEED (LOAD); wins over inv
//     r    out  registered pattern value
module pattern_toggler #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             e,
    input  logic             inv,
    input  logic             load,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;

    always_comb begin
        r_d = r_q;
        if (e) begin
            if (load)     r_d = SEED;
            else if (inv) r_d = ~r_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) r_q <= SEED;
        else     r_q <= r_d;
    end

    assign r = r_q;

endmodule

// File: rtl/accum_counter.sv
// accum_counter
//   Accumulator with four operations selected by mode:
//     ACC  : q <= q + r, r <= ~r
//     ADD  : q <= q + d
//     SUB  : q <= q - d
//     LOAD : q <= d,     r <= SEED
//   Arithmetic is done at WIDTH+1 bits; the top bit is carry/borrow and is
//   registered as a one-cycle ovf pulse. SAT=1 clamps q to all-ones on carry
//   and to zero on borrow; SAT=0 wraps. WIDTH legal range is 2..32.
//   Ports:
//     clk   in   clock, rising edge
//     clr   in   synchronous active-high reset (q=0, r=SEED, ovf=0)
//     e     in   update enable
//     mode  in   operation select (accum_counter_pkg::mode_e)
//     d     in   operand / load value
//     q     out  registered accumulator
//     r_out out  registered pattern register
//     ovf   out  registered carry/borrow pulse
module accum_counter
    import accum_counter_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(alt_pattern(WIDTH)),
    parameter bit               SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             e,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r_out,
    output logic             ovf
);

    mode_e            op;
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   res;
    logic             cb;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;

    assign op = mode_e'(mode);

    pattern_toggler #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_pat (
        .clk  (clk),
        .clr  (clr),
        .e    (e),
        .inv  (op == MODE_ACC),
        .load (op == MODE_LOAD),
        .r    (r)
    );

    // One WIDTH+1 datapath; for SUB the top bit of the difference is the borrow.
    always_comb begin
        unique case (op)
            MODE_ACC: res = {1'b0, q_q} + {1'b0, r};
            MODE_ADD: res = {1'b0, q_q} + {1'b0, d};
            MODE_SUB: res = {1'b0, q_q} - {1'b0, d};
            default:  res = {1'b0, d};
        endcase
    end

    assign cb = res[WIDTH] && (op != MODE_LOAD);

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (e) begin
            if (op == MODE_LOAD) begin
                q_d = d;
            end else begin
                ovf_d = cb;
                if (SAT && cb) q_d = (op == MODE_SUB) ? '0 : '1;
                else           q_d = res[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q     = q_q;
    assign r_out = r;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_accum_counter.sv
// tb_accum_counter
//   Drives three accum_counter instances with identical stimulus:
//     u_w8  : WIDTH=8,  SAT=0
//     u_sat : WIDTH=8,  SAT=1
//     u_w16 : WIDTH=16, SAT=0
//   A reference model predicts every instance's outputs when a step is driven;
//   the prediction is queued and compared after the next rising edge. Directed
//   sequences also check the literal values from the requirements.
module tb_accum_counter;
    import accum_counter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, e;
    logic [1:0]  mode;
    logic [15:0] d;

    logic [7:0]  q0, r0, q1, r1;
    logic [15:0] q2, r2;
    logic        o0, o1, o2;

    accum_counter #(.WIDTH(8), .SAT(1'b0)) u_w8 (
        .clk(clk), .clr(clr), .e(e), .mode(mode), .d(d[7:0]),
        .q(q0), .r_out(r0), .ovf(o0));
    accum_counter #(.WIDTH(8), .SAT(1'b1)) u_sat (
        .clk(clk), .clr(clr), .e(e), .mode(mode), .d(d[7:0]),
        .q(q1), .r_out(r1), .ovf(o1));
    accum_counter #(.WIDTH(16), .SAT(1'b0)) u_w16 (
        .clk(clk), .clr(clr), .e(e), .mode(mode), .d(d),
        .q(q2), .r_out(r2), .ovf(o2));

    typedef struct packed {
        logic [2:0][15:0] q;
        logic [2:0][15:0] r;
        logic [2:0]       o;
    } exp_t;

    exp_t sb[$];

    int unsigned wid  [3] = '{8, 8, 16};
    bit          sat  [3] = '{1'b0, 1'b1, 1'b0};
    int unsigned seed [3] = '{32'hAA, 32'hAA, 32'hAAAA};

    logic [2:0][15:0] mq, mr;
    logic [2:0]       mo;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model(input int k, input bit c, input bit en,
                         input logic [1:0] m, input logic [15:0] dv);
        int unsigned mask, qv, rv, dd, s;
        bit          cb;
        mask = (32'd1 << wid[k]) - 1;
        qv   = 32'(mq[k]);
        rv   = 32'(mr[k]);
        dd   = 32'(dv) & mask;
        s    = 0;
        cb   = 1'b0;
        if (c) begin
            mq[k] = '0; mr[k] = 16'(seed[k]); mo[k] = 1'b0;
        end else if (!en) begin
            mo[k] = 1'b0;
        end else if (m == 2'b11) begin
            mq[k] = 16'(dd); mr[k] = 16'(seed[k]); mo[k] = 1'b0;
        end else begin
            case (m)
                2'b00: begin s = qv + rv; cb = s > mask; mr[k] = 16'(~rv & mask); end
                2'b01: begin s = qv + dd; cb = s > mask; end
                default: begin cb = dd > qv; s = qv - dd; end
            endcase
            if (cb && sat[k]) mq[k] = (m == 2'b10) ? 16'h0 : 16'(mask);
            else              mq[k] = 16'(s & mask);
            mo[k] = cb;
        end
    endtask

    task automatic step(input bit c, input bit en, input logic [1:0] m, input logic [15:0] dv);
        exp_t x;
        @(negedge clk);
        clr = c; e = en; mode = m; d = dv;
        for (int k = 0; k < 3; k++) model(k, c, en, m, dv);
        x.q = mq; x.r = mr; x.o = mo;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("w8.q",   32'(q0), 32'(x.q[0][7:0]));
        chk("w8.r",   32'(r0), 32'(x.r[0][7:0]));
        chk("w8.ovf", 32'(o0), 32'(x.o[0]));
        chk("sat.q",  32'(q1), 32'(x.q[1][7:0]));
        chk("sat.r",  32'(r1), 32'(x.r[1][7:0]));
        chk("sat.ovf",32'(o1), 32'(x.o[1]));
        chk("w16.q",  32'(q2), 32'(x.q[2]));
        chk("w16.r",  32'(r2), 32'(x.r[2]));
        chk("w16.ovf",32'(o2), 32'(x.o[2]));
    endtask

    logic [7:0]  acc_q0 [4] = '{8'hAA, 8'hFF, 8'hA9, 8'hFE};
    logic [7:0]  acc_r0 [4] = '{8'h55, 8'hAA, 8'h55, 8'hAA};
    logic        acc_o0 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  acc_q1 [4] = '{8'hAA, 8'hFF, 8'hFF, 8'hFF};
    logic        acc_o1 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] acc_q2 [2] = '{16'hAAAA, 16'hFFFF};
    logic [15:0] acc_r2 [2] = '{16'h5555, 16'hAAAA};

    initial begin
        clr = 1'b1; e = 1'b0; mode = 2'b00; d = '0;
        mq = '0; mr = '0; mo = '0;

        // reset state
        step(1'b1, 1'b0, MODE_ACC, 16'h0);
        chk("rst.q",   32'(q0), 32'h00);
        chk("rst.r",   32'(r0), 32'hAA);
        chk("rst.ovf", 32'(o0), 32'h0);
        chk("rst.r16", 32'(r2), 32'hAAAA);

        // ACC x4, wrap vs saturate, 16-bit
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, MODE_ACC, 16'h0);
            chk("acc.q",     32'(q0), 32'(acc_q0[i]));
            chk("acc.r",     32'(r0), 32'(acc_r0[i]));
            chk("acc.ovf",   32'(o0), 32'(acc_o0[i]));
            chk("accs.q",    32'(q1), 32'(acc_q1[i]));
            chk("accs.ovf",  32'(o1), 32'(acc_o1[i]));
            if (i < 2) begin
                chk("acc16.q", 32'(q2), 32'(acc_q2[i]));
                chk("acc16.r", 32'(r2), 32'(acc_r2[i]));
            end
        end

        // clr with e=0 after q=FE, then clr dominating LOAD
        step(1'b1, 1'b0, MODE_ADD, 16'h0);
        chk("clr.q",   32'(q0), 32'h00);
        chk("clr.r",   32'(r0), 32'hAA);
        chk("clr.ovf", 32'(o0), 32'h0);
        step(1'b1, 1'b1, MODE_LOAD, 16'h0033);
        chk("clrld.q", 32'(q0), 32'h00);

        // hold with e=0
        step(1'b0, 1'b1, MODE_ACC, 16'h0);
        chk("pre.q", 32'(q0), 32'hAA);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, MODE_ADD, 16'h00FF);
            chk("hold.q",   32'(q0), 32'hAA);
            chk("hold.r",   32'(r0), 32'h55);
            chk("hold.ovf", 32'(o0), 32'h0);
        end

        // LOAD / ADD / SUB borrow
        step(1'b0, 1'b1, MODE_LOAD, 16'h007F);
        chk("ld.r", 32'(r0), 32'hAA);
        step(1'b0, 1'b1, MODE_ADD, 16'h0001);
        chk("add.q",   32'(q0), 32'h80);
        chk("add.ovf", 32'(o0), 32'h0);
        step(1'b0, 1'b1, MODE_SUB, 16'h0081);
        chk("sub.q",    32'(q0), 32'hFF);
        chk("sub.ovf",  32'(o0), 32'h1);
        chk("subs.q",   32'(q1), 32'h00);
        chk("subs.ovf", 32'(o1), 32'h1);

        // zero operands leave q unchanged, ovf drops
        step(1'b0, 1'b1, MODE_ADD, 16'h0);
        chk("add0.q",   32'(q0), 32'hFF);
        chk("add0.ovf", 32'(o0), 32'h0);
        step(1'b0, 1'b1, MODE_SUB, 16'h0);
        chk("sub0.q",   32'(q1), 32'h00);
        chk("sub0.ovf", 32'(o1), 32'h0);

        // mid-sequence reset; next ACC uses SEED
        step(1'b0, 1'b1, MODE_ACC, 16'h0);
        step(1'b1, 1'b1, MODE_ACC, 16'h0);
        step(1'b0, 1'b1, MODE_ACC, 16'h0);
        chk("rsq.q", 32'(q0), 32'hAA);
        chk("rsq.r", 32'(r0), 32'h55);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [15:0] dv;
            dv = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), dv);
        end

        if (sb.size() != 0) chk("sb.empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
